// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for a 16-bit ISA with optional two-word
// (opcode + immediate) instructions. PC_Address is the PC register itself; all
// IF/ID outputs are registered. Per-edge priority: reset > Branch_Taken > Stall
// > advance.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   Instruction         word read from instruction memory at PC_Address
//   Stall               hold PC, FSM, hold registers and IF/ID
//   Branch_Taken        redirect to Branch_Target and squash IF/ID
//   Branch_Target       redirect address
//   PC_Address          current fetch address
//   IF_ID_Instruction   opcode word (NOP_WORD when bubble)
//   IF_ID_Immediate     second word of a two-word instruction, else 0
//   IF_ID_PC            address of the opcode word
//   IF_ID_Valid         IF/ID holds a real instruction
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [15:0] NOP_WORD   = 16'hE200,
  parameter logic [2:0]  IMM_PREFIX = 3'b101
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] Instruction,
  input  logic        Stall,
  input  logic        Branch_Taken,
  input  logic [31:0] Branch_Target,
  output logic [31:0] PC_Address,
  output logic [15:0] IF_ID_Instruction,
  output logic [15:0] IF_ID_Immediate,
  output logic [31:0] IF_ID_PC,
  output logic        IF_ID_Valid
);

  typedef enum logic {
    FETCH = 1'b0,
    IMM   = 1'b1
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [15:0] hold_instr;
  logic [31:0] hold_pc;
  logic        two_word;

  assign PC_Address = pc;
  assign two_word   = (Instruction[15:13] == IMM_PREFIX);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc                <= RESET_PC;
      state             <= FETCH;
      hold_instr        <= '0;
      hold_pc           <= '0;
      IF_ID_Instruction <= NOP_WORD;
      IF_ID_Immediate   <= '0;
      IF_ID_PC          <= '0;
      IF_ID_Valid       <= 1'b0;
    end else if (Branch_Taken) begin
      // Redirect wins over Stall and discards any half-fetched two-word op.
      pc                <= Branch_Target;
      state             <= FETCH;
      hold_instr        <= '0;
      hold_pc           <= '0;
      IF_ID_Instruction <= NOP_WORD;
      IF_ID_Immediate   <= '0;
      IF_ID_PC          <= '0;
      IF_ID_Valid       <= 1'b0;
    end else if (!Stall) begin
      pc <= pc + 32'd1;
      unique case (state)
        FETCH: begin
          if (two_word) begin
            // Park the opcode; IF/ID carries a bubble until the immediate arrives.
            hold_instr        <= Instruction;
            hold_pc           <= pc;
            state             <= IMM;
            IF_ID_Instruction <= NOP_WORD;
            IF_ID_Immediate   <= '0;
            IF_ID_PC          <= '0;
            IF_ID_Valid       <= 1'b0;
          end else begin
            IF_ID_Instruction <= Instruction;
            IF_ID_Immediate   <= '0;
            IF_ID_PC          <= pc;
            IF_ID_Valid       <= 1'b1;
          end
        end
        IMM: begin
          IF_ID_Instruction <= hold_instr;
          IF_ID_Immediate   <= Instruction;
          IF_ID_PC          <= hold_pc;
          IF_ID_Valid       <= 1'b1;
          state             <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage. The stimulus process drives one vector
// per cycle on the falling edge and pushes the expected post-edge outputs into
// a queue; the monitor pops one entry 1 ns after each rising edge and compares.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] Instruction = 16'h0000;
  logic        Stall = 1'b0;
  logic        Branch_Taken = 1'b0;
  logic [31:0] Branch_Target = 32'h0;
  logic [31:0] PC_Address;
  logic [15:0] IF_ID_Instruction;
  logic [15:0] IF_ID_Immediate;
  logic [31:0] IF_ID_PC;
  logic        IF_ID_Valid;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_WORD  (16'hE200),
    .IMM_PREFIX(3'b101)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .Instruction      (Instruction),
    .Stall            (Stall),
    .Branch_Taken     (Branch_Taken),
    .Branch_Target    (Branch_Target),
    .PC_Address       (PC_Address),
    .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_Immediate  (IF_ID_Immediate),
    .IF_ID_PC         (IF_ID_PC),
    .IF_ID_Valid      (IF_ID_Valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [15:0] ins;
    logic [15:0] imm;
    logic [31:0] ifpc;
    logic        v;
    bit          chk_ifpc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cmp(input string name, input string field,
                     input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", name, field, got, want);
    end
  endtask

  // Monitor: one comparison set per clock after the edge settles.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp(e.name, "PC_Address", PC_Address, e.pc);
        cmp(e.name, "IF_ID_Instruction", {16'h0, IF_ID_Instruction}, {16'h0, e.ins});
        cmp(e.name, "IF_ID_Immediate", {16'h0, IF_ID_Immediate}, {16'h0, e.imm});
        cmp(e.name, "IF_ID_Valid", {31'h0, IF_ID_Valid}, {31'h0, e.v});
        if (e.chk_ifpc) cmp(e.name, "IF_ID_PC", IF_ID_PC, e.ifpc);
      end
    end
  end

  task automatic step(input string name, input logic rst, input logic [15:0] ins,
                      input logic stl, input logic br, input logic [31:0] tgt,
                      input logic [31:0] e_pc, input logic [15:0] e_ins,
                      input logic [15:0] e_imm, input logic [31:0] e_ifpc,
                      input logic e_v, input bit e_chk_ifpc);
    exp_t e;
    @(negedge clk);
    reset = rst;
    Instruction = ins;
    Stall = stl;
    Branch_Taken = br;
    Branch_Target = tgt;
    e.name = name;
    e.pc = e_pc;
    e.ins = e_ins;
    e.imm = e_imm;
    e.ifpc = e_ifpc;
    e.v = e_v;
    e.chk_ifpc = e_chk_ifpc;
    exp_q.push_back(e);
  endtask

  initial begin
    //    name          rst ins       stl br tgt            pc            ins       imm       ifpc          v  ifpc?
    step("reset",       1, 16'h0000, 0, 0, 32'h0,        32'h0,        16'hE200, 16'h0000, 32'h0,        0, 1);
    step("one_word_a",  0, 16'h1234, 0, 0, 32'h0,        32'h1,        16'h1234, 16'h0000, 32'h0,        1, 1);
    step("one_word_b",  0, 16'h2345, 0, 0, 32'h0,        32'h2,        16'h2345, 16'h0000, 32'h1,        1, 1);
    step("br_to_0",     0, 16'h0000, 0, 1, 32'h0,        32'h0,        16'hE200, 16'h0000, 32'h0,        0, 1);
    step("two_opcode",  0, 16'hA001, 0, 0, 32'h0,        32'h1,        16'hE200, 16'h0000, 32'h0,        0, 0);
    step("two_imm",     0, 16'h00FF, 0, 0, 32'h0,        32'h2,        16'hA001, 16'h00FF, 32'h0,        1, 1);
    step("br_to_4",     0, 16'h0000, 0, 1, 32'h4,        32'h4,        16'hE200, 16'h0000, 32'h0,        0, 1);
    step("fetch_4",     0, 16'h1111, 0, 0, 32'h0,        32'h5,        16'h1111, 16'h0000, 32'h4,        1, 1);
    for (int unsigned i = 0; i < 3; i++)
      step("stall_at_5", 0, 16'hA777, 1, 0, 32'h0,       32'h5,        16'h1111, 16'h0000, 32'h4,        1, 1);
    step("resume_5",    0, 16'h0042, 0, 0, 32'h0,        32'h6,        16'h0042, 16'h0000, 32'h5,        1, 1);
    step("imm_opcode",  0, 16'hA123, 0, 0, 32'h0,        32'h7,        16'hE200, 16'h0000, 32'h0,        0, 0);
    for (int unsigned i = 0; i < 2; i++)
      step("stall_imm",  0, 16'h0BAD, 1, 0, 32'h0,       32'h7,        16'hE200, 16'h0000, 32'h0,        0, 0);
    step("imm_release", 0, 16'hA0A0, 0, 0, 32'h0,        32'h8,        16'hA123, 16'hA0A0, 32'h6,        1, 1);
    step("br_opcode",   0, 16'hA555, 0, 0, 32'h0,        32'h9,        16'hE200, 16'h0000, 32'h0,        0, 0);
    step("br_in_imm",   0, 16'h9999, 1, 1, 32'h40,       32'h40,       16'hE200, 16'h0000, 32'h0,        0, 1);
    step("after_br",    0, 16'h0123, 0, 0, 32'h0,        32'h41,       16'h0123, 16'h0000, 32'h40,       1, 1);
    step("br_to_max",   0, 16'h0000, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'hE200, 16'h0000, 32'h0,      0, 1);
    step("pc_wrap",     0, 16'h3333, 0, 0, 32'h0,        32'h0,        16'h3333, 16'h0000, 32'hFFFF_FFFF, 1, 1);
    step("rst_opcode",  0, 16'hA0F0, 0, 0, 32'h0,        32'h1,        16'hE200, 16'h0000, 32'h0,        0, 0);
    step("rst_in_imm",  1, 16'h5555, 1, 1, 32'h80,       32'h0,        16'hE200, 16'h0000, 32'h0,        0, 1);
    step("after_rst",   0, 16'h4444, 0, 0, 32'h0,        32'h1,        16'h4444, 16'h0000, 32'h0,        1, 1);

    for (int unsigned n = 0; n < 20 && exp_q.size() > 0; n++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0 pending", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
